// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Level of a dark line for a given drive polarity.
  function automatic logic off_lvl(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Bundle between the board top level and the display scanner.
// master drives display data and handshake; slave is the scanner.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic                    clk_en;
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_blank;
  logic                    load;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output clk_en, enable, data_in, dp_in,
    output blank_mask, lz_blank, load,
    input  load_ack, an, seg, dp, frame_start
  );

  modport slave (
    input  clk_en, enable, data_in, dp_in,
    input  blank_mask, lz_blank, load,
    output load_ack, an, seg, dp, frame_start
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Hex nibble to active-high seven-segment pattern.
// Purely combinational; polarity is applied by the parent.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  assign pat = SEG_TAB[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with shadowed display data
// and an optional blanking gap between digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SHOW_TICKS     = 1,
  parameter int BLANK_TICKS    = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic       clk,
  input logic       reset,
  seg7_scan_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;
  localparam int CW = 16;
  localparam int ND = NUM_DIGITS;

  localparam logic [IW-1:0] LAST  = IW'(ND - 1);
  localparam logic [CW-1:0] S_END = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] B_END =
    CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  localparam logic [ND-1:0] AN_OFF =
    {ND{off_lvl(AN_ACTIVE_LOW)}};
  localparam logic [6:0] SEG_OFF =
    {7{off_lvl(SEG_ACTIVE_LOW)}};
  localparam logic DP_OFF = off_lvl(SEG_ACTIVE_LOW);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n, idx_adv;
  logic [CW-1:0]   cnt, cnt_n;
  logic            wrap, bnd;

  logic            pend, pend_l, pend_n, cap;
  logic [4*ND-1:0] sh_data, data_n;
  logic [ND-1:0]   sh_dp, sdp_n;
  logic [ND-1:0]   sh_mask, mask_n;

  logic            hi_zero, lit;
  logic [ND-1:0]   oh;
  logic [3:0]      nib;
  logic [6:0]      pat;

  logic [ND-1:0]   an_d, an_q;
  logic [6:0]      seg_d, seg_q;
  logic            dp_d, dp_q;
  logic            ack_q, fs_q;

  assign wrap    = (idx == LAST);
  assign idx_adv = wrap ? '0 : idx + 1'b1;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    bnd     = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (bus.clk_en) begin
      unique case (state)
        IDLE: begin
          state_n = SHOW;
          idx_n   = '0;
          cnt_n   = '0;
          bnd     = 1'b1;
        end
        SHOW: begin
          if (cnt == S_END) begin
            cnt_n = '0;
            if (BLANK_TICKS > 0) begin
              state_n = BLANK;
            end else begin
              idx_n = idx_adv;
              bnd   = wrap;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == B_END) begin
            cnt_n   = '0;
            state_n = SHOW;
            idx_n   = idx_adv;
            bnd     = wrap;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-cycle state so the
  // freshly captured shadow shows in the first SHOW cycle.
  always_comb begin
    pend_l = pend | bus.load;
    cap    = bnd & pend_l;
    pend_n = pend_l & ~cap;
    data_n = cap ? bus.data_in    : sh_data;
    sdp_n  = cap ? bus.dp_in      : sh_dp;
    mask_n = cap ? bus.blank_mask : sh_mask;

    hi_zero = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (i >= int'(idx_n) &&
          data_n[4*i +: 4] != 4'h0)
        hi_zero = 1'b0;
    end

    nib = data_n[4*int'(idx_n) +: 4];
    lit = (state_n == SHOW) &&
          !mask_n[idx_n] &&
          !(bus.lz_blank && idx_n != '0 && hi_zero);

    oh        = '0;
    oh[idx_n] = 1'b1;
    an_d  = lit ? (AN_OFF ^ oh) : AN_OFF;
    seg_d = SEG_OFF ^ (lit ? pat : 7'h00);
    dp_d  = DP_OFF ^ (lit & sdp_n[idx_n]);
  end

  hex_to_seg7 u_hex (
    .nib (nib),
    .pat (pat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      sh_data <= '0;
      sh_dp   <= '0;
      sh_mask <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      sh_data <= data_n;
      sh_dp   <= sdp_n;
      sh_mask <= mask_n;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ack_q   <= cap;
      fs_q    <= bnd;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: positional frame model checked every
// cycle, plus directed vectors with literal expectations.
module tb_seg7_scan_ctrl;

  localparam int N     = 8;
  localparam int S     = 1;
  localparam int B     = 1;
  localparam int SLOT  = S + B;
  localparam int FRAME = N * SLOT;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ack_cnt = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS     (N),
    .SHOW_TICKS     (S),
    .BLANK_TICKS    (B),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          act;
    int          pos;
    logic [31:0] data;
    logic [7:0]  dpr;
    logic [7:0]  mask;
    bit          pend;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        ack;
    logic        fs;
    bit          care;
  } mdl_t;

  mdl_t m;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06;
      4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D;
      4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F;
      4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E;
      4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.act = 0; r.pos = 0; r.data = '0;
    r.dpr = '0; r.mask = '0; r.pend = 0;
    r.an = 8'hFF; r.seg = 7'h7F; r.dp = 1'b1;
    r.ack = 1'b0; r.fs = 1'b0; r.care = 1;
    return r;
  endfunction

  // Frame position counts ticks since digit 0 lit; digit and
  // show/blank phase follow from it arithmetically.
  function automatic mdl_t mdl_step(
    input mdl_t c, input logic en, input logic tick,
    input logic ld, input logic [31:0] din,
    input logic [7:0] dpi, input logic [7:0] msk,
    input logic lz
  );
    mdl_t r;
    bit bnd, show, dark;
    int d;
    r = c;
    bnd = 0;
    r.pend = c.pend | ld;
    if (!en) begin
      r.act = 0; r.pos = 0;
    end else if (tick) begin
      if (!c.act) begin
        r.act = 1; r.pos = 0; bnd = 1;
      end else begin
        r.pos = (c.pos + 1) % FRAME;
        bnd = (r.pos == 0);
      end
    end
    r.fs  = bnd;
    r.ack = bnd && r.pend;
    if (bnd && r.pend) begin
      r.data = din; r.dpr = dpi;
      r.mask = msk; r.pend = 0;
    end
    d    = r.pos / SLOT;
    show = r.act && ((r.pos % SLOT) < S);
    dark = r.mask[d] ||
           (lz && d > 0 && (r.data >> (4*d)) == 0);
    r.care = !(show && dark);
    if (show && !dark) begin
      r.an  = ~(8'h01 << d);
      r.seg = ~hexpat(r.data[4*d +: 4]);
      r.dp  = ~r.dpr[d];
    end else begin
      r.an = 8'hFF; r.seg = 7'h7F; r.dp = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)
      m <= mdl_rst();
    else
      m <= mdl_step(m, bus.enable, bus.clk_en,
                    bus.load, bus.data_in, bus.dp_in,
                    bus.blank_mask, bus.lz_blank);
  end

  always @(negedge clk) begin
    tests++;
    if (bus.an !== m.an ||
        bus.load_ack !== m.ack ||
        bus.frame_start !== m.fs ||
        (m.care && (bus.seg !== m.seg ||
                    bus.dp !== m.dp))) begin
      fails++;
      $display("FAIL model t=%0t an=%h/%h seg=%h/%h dp=%b/%b ack=%b/%b fs=%b/%b",
               $time, bus.an, m.an, bus.seg, m.seg,
               bus.dp, m.dp, bus.load_ack, m.ack,
               bus.frame_start, m.fs);
    end
    if (bus.load_ack === 1'b1) ack_cnt++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.clk_en     = 1'b0;
    bus.enable     = 1'b1;
    bus.data_in    = '0;
    bus.dp_in      = '0;
    bus.blank_mask = '0;
    bus.lz_blank   = 1'b0;
    bus.load       = 1'b0;
    #1 reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("rst_an", bus.an, 8'hFF);
      chk("rst_seg", bus.seg, 7'h7F);
      chk("rst_dp", bus.dp, 1'b1);
      chk("rst_ack", bus.load_ack, 1'b0);
      chk("rst_fs", bus.frame_start, 1'b0);
      bus.clk_en = ~bus.clk_en;
    end
    @(negedge clk);
    #2;
    bus.enable = 1'b0;
    bus.clk_en = 1'b1;
    reset      = 1'b1;

    step(1);
    bus.data_in = 32'h1234ABCD;
    bus.load    = 1'b1;
    bus.enable  = 1'b1;
    step(1);
    chk("c0_ack", bus.load_ack, 1'b1);
    chk("c0_fs", bus.frame_start, 1'b1);
    chk("c0_an", bus.an, 8'hFE);
    chk("c0_seg", bus.seg, 7'h21);
    bus.load = 1'b0;
    step(1);
    chk("c1_blank", bus.an, 8'hFF);
    step(1);
    chk("c2_an", bus.an, 8'hFD);
    chk("c2_seg", bus.seg, 7'h46);
    step(12);
    chk("d7_an", bus.an, 8'h7F);
    chk("d7_seg", bus.seg, 7'h79);
    step(2);
    chk("wrap_fs", bus.frame_start, 1'b1);
    chk("wrap_an", bus.an, 8'hFE);
    chk("wrap_ack", bus.load_ack, 1'b0);

    step(6);
    chk("d3_an", bus.an, 8'hF7);
    chk("d3_seg", bus.seg, 7'h08);
    bus.data_in = 32'h0;
    bus.load    = 1'b1;
    step(1);
    bus.load = 1'b0;
    chk("mid_noack", bus.load_ack, 1'b0);
    step(9);
    chk("mid_ack", bus.load_ack, 1'b1);
    chk("mid_fs", bus.frame_start, 1'b1);
    chk("mid_seg0", bus.seg, 7'h40);

    bus.lz_blank = 1'b1;
    bus.data_in  = 32'h00000050;
    bus.load     = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(15);
    chk("lz_ack", bus.load_ack, 1'b1);
    chk("lz_d0_an", bus.an, 8'hFE);
    chk("lz_d0_seg", bus.seg, 7'h40);
    step(2);
    chk("lz_d1_an", bus.an, 8'hFD);
    chk("lz_d1_seg", bus.seg, 7'h12);
    step(2);
    chk("lz_d2_dark", bus.an, 8'hFF);

    bus.lz_blank   = 1'b0;
    bus.blank_mask = 8'h04;
    bus.dp_in      = 8'h10;
    bus.data_in    = 32'h1234ABCD;
    bus.load       = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(11);
    chk("mk_ack", bus.load_ack, 1'b1);
    chk("mk_d0_dp", bus.dp, 1'b1);
    step(4);
    chk("mk_d2_dark", bus.an, 8'hFF);
    step(4);
    chk("mk_d4_an", bus.an, 8'hEF);
    chk("mk_d4_dp", bus.dp, 1'b0);
    step(2);
    chk("en_d5_an", bus.an, 8'hDF);
    bus.enable = 1'b0;
    step(1);
    chk("en_off_an", bus.an, 8'hFF);
    step(1);
    bus.enable = 1'b1;
    step(1);
    chk("en_re_an", bus.an, 8'hFE);
    chk("en_re_fs", bus.frame_start, 1'b1);

    step(3);
    bus.data_in = 32'hFFFFFFFF;
    bus.load    = 1'b1;
    step(1);
    bus.load = 1'b0;
    @(negedge clk);
    #2;
    reset   = 1'b0;
    ack_cnt = 0;
    step(2);
    #2;
    reset = 1'b1;
    step(40);
    chk("rst_noack", ack_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
